// File: rtl/student_iis_clk_ctrl_if.sv
// student_iis_clk_ctrl_if
//   Bundles the IIS timing signals between the clock controller and the
//   audio path.
//   en_i        run request (level) into the controller
//   AC_MCLK     codec master clock
//   AC_BCLK     codec bit clock
//   AC_LRCLK    codec word clock, 0 = left, 1 = right
//   BCLK_Rise   one-cycle strobe, first cycle with AC_BCLK high
//   BCLK_Fall   one-cycle strobe, first cycle with AC_BCLK low
//   LRCLK_Rise  one-cycle strobe, first cycle with AC_LRCLK high
//   LRCLK_Fall  one-cycle strobe, first cycle with AC_LRCLK low
//   running_o   high while the serial clocks are active
//   master modport: the clock controller; slave modport: the consumer.
interface student_iis_clk_ctrl_if;
  logic en_i;
  logic AC_MCLK;
  logic AC_BCLK;
  logic AC_LRCLK;
  logic BCLK_Rise;
  logic BCLK_Fall;
  logic LRCLK_Rise;
  logic LRCLK_Fall;
  logic running_o;

  modport master (
    input  en_i,
    output AC_MCLK, AC_BCLK, AC_LRCLK,
    output BCLK_Rise, BCLK_Fall, LRCLK_Rise, LRCLK_Fall,
    output running_o
  );

  modport slave (
    output en_i,
    input  AC_MCLK, AC_BCLK, AC_LRCLK,
    input  BCLK_Rise, BCLK_Fall, LRCLK_Rise, LRCLK_Fall,
    input  running_o
  );
endinterface

// File: rtl/student_iis_clk_ctrl.sv
// student_iis_clk_ctrl
//   Timing master for the IIS audio path. Divides clk_i into MCLK, BCLK and
//   LRCLK, emits one-cycle edge strobes, and starts/stops the serial frame on
//   a frame boundary under control of en_i.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     master side of student_iis_clk_ctrl_if (en_i in, clocks,
//           strobes and running_o out; all outputs registered)
//
//   state | meaning
//   IDLE  | serial clocks parked low, counters cleared
//   RUN   | serial clocks running
//   DRAIN | clocks running, stop at the next end of the right channel
module student_iis_clk_ctrl #(
  parameter int MCLK_DIV    = 4,
  parameter int BCLK_DIV    = 16,
  parameter int BITS_PER_CH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  student_iis_clk_ctrl_if.master bus
);

  localparam int MW = (MCLK_DIV    > 1) ? $clog2(MCLK_DIV)    : 1;
  localparam int DW = (BCLK_DIV    > 1) ? $clog2(BCLK_DIV)    : 1;
  localparam int BW = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;

  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_CH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [MW-1:0] mclk_cnt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          mclk, bclk, lrclk;
  logic          bclk_rise, bclk_fall, lrclk_rise, lrclk_fall;
  logic          running;

  logic div_wrap, bclk_rise_ev, bclk_fall_ev, lr_wrap, clear_serial;

  // MCLK is free-running whenever out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
    end else if (mclk_cnt == MCLK_LAST) begin
      mclk_cnt <= '0;
      mclk     <= ~mclk;
    end else begin
      mclk_cnt <= mclk_cnt + 1'b1;
    end
  end

  // lrclk_fall is the registered strobe, so DRAIN leaves one cycle after the
  // end-of-frame edge has been driven onto the pins.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.en_i) state_nxt = ST_RUN;
      ST_RUN:   if (!bus.en_i) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.en_i)        state_nxt = ST_RUN;
        else if (lrclk_fall) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign div_wrap     = (div_cnt == DIV_LAST);
  assign bclk_rise_ev = div_wrap & ~bclk;
  assign bclk_fall_ev = div_wrap &  bclk;
  assign lr_wrap      = bclk_fall_ev & (bit_cnt == BIT_LAST);
  // Clearing on state_nxt as well keeps the counters at zero from the very
  // first IDLE cycle, so a restart always begins from a clean frame.
  assign clear_serial = (state == ST_IDLE) || (state_nxt == ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      bclk_rise  <= 1'b0;
      bclk_fall  <= 1'b0;
      lrclk_rise <= 1'b0;
      lrclk_fall <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt != ST_IDLE);
      if (clear_serial) begin
        div_cnt    <= '0;
        bit_cnt    <= '0;
        bclk       <= 1'b0;
        lrclk      <= 1'b0;
        bclk_rise  <= 1'b0;
        bclk_fall  <= 1'b0;
        lrclk_rise <= 1'b0;
        lrclk_fall <= 1'b0;
      end else begin
        div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
        bclk       <= bclk ^ div_wrap;
        bclk_rise  <= bclk_rise_ev;
        bclk_fall  <= bclk_fall_ev;
        // LRCLK only moves on a BCLK fall, so the MSB follows one bit later.
        if (bclk_fall_ev)
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        lrclk      <= lrclk ^ lr_wrap;
        lrclk_rise <= lr_wrap & ~lrclk;
        lrclk_fall <= lr_wrap &  lrclk;
      end
    end
  end

  assign bus.AC_MCLK    = mclk;
  assign bus.AC_BCLK    = bclk;
  assign bus.AC_LRCLK   = lrclk;
  assign bus.BCLK_Rise  = bclk_rise;
  assign bus.BCLK_Fall  = bclk_fall;
  assign bus.LRCLK_Rise = lrclk_rise;
  assign bus.LRCLK_Fall = lrclk_fall;
  assign bus.running_o  = running;

endmodule
